// File: rtl/cmd_link_sequencer.sv
// Sequences a 3-byte pilot command frame (sync, encrypted cmd, checksum) through the
// OTP encryption unit and the UART transmitter, on input change or heartbeat.
module cmd_link_sequencer #(
   parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
   parameter int unsigned HEARTBEAT_CYCLES = 3840000,
   parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode,
   input  logic [1:0] upDown,
   input  logic [1:0] forwardBack,
   input  logic [1:0] rightLeft,
   output logic [7:0] enc_data,
   output logic       enc_passthrough,
   output logic       enc_start,
   input  logic [7:0] enc_result,
   input  logic       enc_done,
   output logic [7:0] uart_tx,
   output logic       uart_load_data,
   output logic       start_uart,
   input  logic       tx_done,
   output logic       busy,
   output logic       frame_sent,
   output logic       timeout_err,
   output logic [7:0] frame_count
);

   localparam int unsigned HbW = $clog2(HEARTBEAT_CYCLES);
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [HbW-1:0] HbLast = HbW'(HEARTBEAT_CYCLES - 1);
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StEncReq, StEncWait, StLoad, StStart, StTxWait} state_t;

   state_t           r_state;
   logic [1:0]       r_idx;
   logic [7:0]       r_cmd_lat;
   logic [7:0]       r_last_cmd;
   logic [HbW-1:0]   r_hb_cnt;
   logic [ToW-1:0]   r_wait;

   logic [6:0]       w_bits;
   logic [7:0]       w_cmd;
   logic             w_trigger;

   assign w_bits    = {mode, upDown, forwardBack, rightLeft};
   assign w_cmd     = {w_bits, ^w_bits};
   assign w_trigger = (w_cmd != r_last_cmd) || (r_hb_cnt == HbLast);
   assign busy      = (r_state != StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= StIdle;
         r_idx           <= 2'd0;
         r_cmd_lat       <= 8'h00;
         r_last_cmd      <= 8'h00;
         r_hb_cnt        <= '0;
         r_wait          <= '0;
         enc_data        <= 8'h00;
         enc_passthrough <= 1'b0;
         enc_start       <= 1'b0;
         uart_tx         <= 8'h00;
         uart_load_data  <= 1'b0;
         start_uart      <= 1'b0;
         frame_sent      <= 1'b0;
         timeout_err     <= 1'b0;
         frame_count     <= 8'h00;
      end else begin
         enc_start      <= 1'b0;
         uart_load_data <= 1'b0;
         start_uart     <= 1'b0;
         frame_sent     <= 1'b0;
         timeout_err    <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_trigger) begin
                  r_state         <= StEncReq;
                  r_idx           <= 2'd0;
                  r_cmd_lat       <= w_cmd;
                  r_hb_cnt        <= '0;
                  enc_data        <= SYNC_BYTE;
                  enc_passthrough <= 1'b1;
                  enc_start       <= 1'b1;
               end else if (r_hb_cnt != HbLast) begin
                  r_hb_cnt <= r_hb_cnt + HbW'(1);
               end
            end
            StEncReq: begin
               r_state <= StEncWait;
               r_wait  <= '0;
            end
            StEncWait: begin
               if (enc_done) begin
                  uart_tx        <= enc_result;
                  uart_load_data <= 1'b1;
                  r_state        <= StLoad;
               end else if (r_wait == ToLast) begin
                  timeout_err <= 1'b1;
                  r_hb_cnt    <= '0;
                  r_state     <= StIdle;
               end else begin
                  r_wait <= r_wait + ToW'(1);
               end
            end
            StLoad: begin
               start_uart <= 1'b1;
               r_state    <= StStart;
            end
            StStart: begin
               r_state <= StTxWait;
               r_wait  <= '0;
            end
            StTxWait: begin
               if (tx_done) begin
                  uart_tx <= 8'h00;
                  if (r_idx != 2'd2) begin
                     r_idx     <= r_idx + 2'd1;
                     r_state   <= StEncReq;
                     enc_start <= 1'b1;
                     // uart_tx still holds the encrypted cmd byte when leaving byte1
                     if (r_idx == 2'd0) begin
                        enc_data        <= r_cmd_lat;
                        enc_passthrough <= 1'b0;
                     end else begin
                        enc_data        <= SYNC_BYTE ^ uart_tx;
                        enc_passthrough <= 1'b1;
                     end
                  end else begin
                     r_last_cmd  <= r_cmd_lat;
                     frame_count <= frame_count + 8'd1;
                     frame_sent  <= 1'b1;
                     r_state     <= StIdle;
                  end
               end else if (r_wait == ToLast) begin
                  uart_tx     <= 8'h00;
                  timeout_err <= 1'b1;
                  r_hb_cnt    <= '0;
                  r_state     <= StIdle;
               end else begin
                  r_wait <= r_wait + ToW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_link_sequencer.sv
// Directed bench for cmd_link_sequencer: XOR-0x3C encryption model, latency-programmable
// UART model, and a byte scoreboard checked at each frame_sent.
module tb_cmd_link_sequencer;

   localparam logic [7:0] SYNC    = 8'hA5;
   localparam logic [7:0] ENC_KEY = 8'h3C;
   localparam int ENC_LAT  = 2;
   localparam int UART_LAT = 3;

   logic       clk;
   logic       reset;
   logic       mode;
   logic [1:0] upDown, forwardBack, rightLeft;
   logic [7:0] enc_data, enc_result, uart_tx, frame_count;
   logic       enc_passthrough, enc_start, enc_done, uart_load_data, start_uart, tx_done;
   logic       busy, frame_sent, timeout_err;

   logic enc_done_m, tx_done_m, spur_idle, spur_load, spur_load_en, mute;
   int   enc_cd, tx_cd;
   logic [7:0] enc_d_l;
   logic       enc_pt_l;
   logic prev_enc_start, prev_load, prev_start, prev_fs;
   int   lat_err;

   int vectors;
   int miscompares;

   logic [7:0] exp_tx_q[$], obs_q[$];
   logic [8:0] exp_enc_q[$], enc_q[$];

   logic [30:0] outs;
   assign outs = {enc_data, enc_passthrough, enc_start, uart_tx, uart_load_data, start_uart,
                  busy, frame_sent, timeout_err, frame_count};

   assign enc_done = enc_done_m | spur_idle | spur_load;
   assign tx_done  = tx_done_m | spur_idle | spur_load;

   cmd_link_sequencer #(
      .SYNC_BYTE        (SYNC),
      .HEARTBEAT_CYCLES (1000),
      .TIMEOUT_CYCLES   (64)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mode            (mode),
      .upDown          (upDown),
      .forwardBack     (forwardBack),
      .rightLeft       (rightLeft),
      .enc_data        (enc_data),
      .enc_passthrough (enc_passthrough),
      .enc_start       (enc_start),
      .enc_result      (enc_result),
      .enc_done        (enc_done),
      .uart_tx         (uart_tx),
      .uart_load_data  (uart_load_data),
      .start_uart      (start_uart),
      .tx_done         (tx_done),
      .busy            (busy),
      .frame_sent      (frame_sent),
      .timeout_err     (timeout_err),
      .frame_count     (frame_count)
   );

   always #5 clk = ~clk;

   // Models, capture and strobe-protocol monitor, all on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         enc_cd = 0; tx_cd = 0; enc_done_m = 0; tx_done_m = 0; spur_load = 0;
         prev_enc_start = 0; prev_load = 0; prev_start = 0; prev_fs = 0;
      end else begin
         if (enc_start && prev_enc_start) lat_err++;
         if (uart_load_data && (prev_load || !enc_done_m)) lat_err++;
         if (start_uart && (prev_start || !prev_load)) lat_err++;
         if (frame_sent && prev_fs) lat_err++;
         if (tx_done_m && !(enc_start ^ frame_sent)) lat_err++;
         if (uart_load_data) obs_q.push_back(uart_tx);
         if (enc_start) enc_q.push_back({enc_passthrough, enc_data});
         prev_enc_start = enc_start; prev_load = uart_load_data;
         prev_start = start_uart; prev_fs = frame_sent;
         enc_done_m = 0;
         if (enc_cd > 0) begin
            enc_cd--;
            if (enc_cd == 0) begin
               enc_done_m = 1;
               enc_result = enc_pt_l ? enc_d_l : (enc_d_l ^ ENC_KEY);
            end
         end
         if (enc_start) begin
            enc_cd = ENC_LAT; enc_d_l = enc_data; enc_pt_l = enc_passthrough;
         end
         tx_done_m = 0;
         if (tx_cd > 0) begin
            tx_cd--;
            if (tx_cd == 0) tx_done_m = 1;
         end
         if (start_uart && !mute) tx_cd = UART_LAT;
         spur_load = spur_load_en && uart_load_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] calc_cmd(input logic m, input logic [1:0] ud,
                                           input logic [1:0] fb, input logic [1:0] rl);
      logic [6:0] b;
      b = {m, ud, fb, rl};
      return {b, ^b};
   endfunction

   task automatic push_frame(input logic [7:0] cmd);
      logic [7:0] b1;
      b1 = cmd ^ ENC_KEY;
      exp_tx_q.push_back(SYNC);
      exp_tx_q.push_back(b1);
      exp_tx_q.push_back(SYNC ^ b1);
      exp_enc_q.push_back({1'b1, SYNC});
      exp_enc_q.push_back({1'b0, cmd});
      exp_enc_q.push_back({1'b1, SYNC ^ b1});
   endtask

   task automatic clear_q();
      exp_tx_q.delete(); obs_q.delete(); exp_enc_q.delete(); enc_q.delete();
   endtask

   task automatic cmp_frame(input string tag);
      logic [8:0] e, o;
      chk({tag, "_ntx"}, 32'(obs_q.size()), 32'(exp_tx_q.size()));
      chk({tag, "_nenc"}, 32'(enc_q.size()), 32'(exp_enc_q.size()));
      while (exp_tx_q.size() != 0) begin
         e = {1'b0, exp_tx_q.pop_front()};
         if (obs_q.size() != 0) o = {1'b0, obs_q.pop_front()};
         else o = 'x;
         chk({tag, "_tx"}, 32'(o), 32'(e));
      end
      while (exp_enc_q.size() != 0) begin
         e = exp_enc_q.pop_front();
         if (enc_q.size() != 0) o = enc_q.pop_front();
         else o = 'x;
         chk({tag, "_enc"}, 32'(o), 32'(e));
      end
      obs_q.delete(); enc_q.delete();
   endtask

   task automatic wait_frame(input int chg_at);
      int  n, starts;
      bit  done;
      n = 0; starts = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         n++;
         if (start_uart) begin
            starts++;
            if (starts == chg_at) rightLeft = 2'b11;
         end
         if (frame_sent) done = 1;
         else if (n >= 3000) begin
            chk("frame_wait", 32'(frame_sent), 32'd1);
            done = 1;
         end
      end
   endtask

   task automatic wait_enc_start(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!enc_start && n < 3000);
   endtask

   initial begin
      int n, idle_bad;
      vectors = 0; miscompares = 0; lat_err = 0;
      clk = 0; reset = 0; mute = 0; spur_idle = 0; spur_load_en = 0;
      enc_done_m = 0; tx_done_m = 0; spur_load = 0; enc_result = 8'h00;
      mode = 1'b1; upDown = 2'b01; forwardBack = 2'b10; rightLeft = 2'b00;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'(outs), 32'd0);

      // First frame: cmd 0xB1 -> A5, 8D, 28
      push_frame(8'hB1);
      reset = 1;
      wait_frame(0);
      cmp_frame("first");
      chk("count_1", 32'(frame_count), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);

      // Heartbeat gap with spurious done pulses while idle
      idle_bad = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!enc_start && (busy || uart_load_data || start_uart || frame_sent || timeout_err))
            idle_bad++;
         spur_idle = (n == 5 || n == 6);
      end while (!enc_start && n < 3000);
      spur_idle = 0;
      chk("hb_gap", 32'(n), 32'd1000);
      chk("idle_spurious", 32'(idle_bad), 32'd0);

      // Heartbeat frame, spurious dones in LOAD, rightLeft changed during byte1 TX_WAIT
      spur_load_en = 1;
      push_frame(8'hB1);
      wait_frame(2);
      spur_load_en = 0;
      cmp_frame("hb_frame");
      chk("count_2", 32'(frame_count), 32'd2);

      push_frame(8'hB7);
      wait_enc_start(n);
      chk("chg_gap", 32'(n), 32'd1);
      wait_frame(0);
      cmp_frame("chg_frame");
      chk("count_3", 32'(frame_count), 32'd3);

      // UART never answers: abort after 64 TX_WAIT cycles, then retry
      mute = 1;
      forwardBack = 2'b01;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!start_uart && n < 300);
      chk("to_start_seen", 32'(start_uart), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout_err && n < 300);
      chk("to_latency", 32'(n), 32'd65);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_count", 32'(frame_count), 32'd3);
      clear_q();
      mute = 0;
      push_frame(8'hAF);
      @(negedge clk);
      chk("retry_start", 32'(enc_start), 32'd1);
      wait_frame(0);
      cmp_frame("retry_frame");
      chk("count_4", 32'(frame_count), 32'd4);

      // Reset during ENC_WAIT of byte1
      mode = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(enc_start && !enc_passthrough) && n < 300);
      @(negedge clk);
      chk("pre_rst_enc_data", 32'(enc_data), 32'h2E);
      reset = 0;
      #1;
      chk("async_reset", 32'(outs), 32'd0);
      clear_q();
      repeat (3) @(negedge clk);
      push_frame(8'h2E);
      reset = 1;
      wait_frame(0);
      cmp_frame("rst_frame");
      chk("count_rst", 32'(frame_count), 32'd1);

      // Frame counter wrap
      for (int f = 2; f <= 256; f++) begin
         rightLeft = rightLeft ^ 2'b01;
         push_frame(calc_cmd(mode, upDown, forwardBack, rightLeft));
         wait_frame(0);
         cmp_frame("wrap");
         if (f == 255) chk("count_255", 32'(frame_count), 32'd255);
      end
      chk("count_wrap", 32'(frame_count), 32'd0);
      chk("strobe_protocol", 32'(lat_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cmd_link_sequencer.md
Name: cmd_link_sequencer

Overview:
Controller that turns the pilot control inputs (mode, upDown, forwardBack, rightLeft) into a 3-byte command frame. It sequences each byte through the OTP encryption/decryption unit and then through the UART transmitter, one byte at a time. Frames are sent when the control inputs change, or on a heartbeat timer when they do not. It sits between the top-level control inputs and the otp_encryption_decryption / top_level_uart instances.

Parameters:
SYNC_BYTE, 8'hA5, frame header value; sent in passthrough.
HEARTBEAT_CYCLES, 3840000, clocks between forced resends when inputs are unchanged (100 ms at 38.4 MHz).
TIMEOUT_CYCLES, 65535, maximum clocks to wait for enc_done or tx_done before aborting.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
mode  in  1  flight mode.
upDown  in  2  vertical command.
forwardBack  in  2  pitch command.
rightLeft  in  2  roll command.
enc_data  out  8  byte presented to the encryption unit.
enc_passthrough  out  1  1 = encryption unit returns the byte unmodified.
enc_start  out  1  one-cycle start pulse to the encryption unit.
enc_result  in  8  encryption unit output byte.
enc_done  in  1  encryption unit result valid.
uart_tx  out  8  byte to transmit.
uart_load_data  out  1  one-cycle load strobe.
start_uart  out  1  one-cycle transmit start.
tx_done  in  1  UART byte complete.
busy  out  1  1 whenever the FSM is not in IDLE.
frame_sent  out  1  one-cycle pulse when the 3rd byte's tx_done is accepted.
timeout_err  out  1  one-cycle pulse when a frame is aborted.
frame_count  out  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Command byte (combinational): cmd = {mode, upDown, forwardBack, rightLeft, p}, where p = XOR of cmd[7:1] (even parity over all 8 bits).
- Frame format:
  - byte0 = SYNC_BYTE, passthrough = 1.
  - byte1 = cmd, passthrough = 0; the encrypted value from enc_result is what is sent.
  - byte2 = SYNC_BYTE ^ encrypted byte1, passthrough = 1.
- Reset values: all outputs 0. Internal state: last_cmd = 8'h00, hb_cnt = 0, byte index = 0, state IDLE.
- Heartbeat counter:
  - Increments every cycle while in IDLE; saturates at HEARTBEAT_CYCLES-1.
  - Clears on frame start.
- Trigger (IDLE only): start a frame when cmd != last_cmd OR hb_cnt == HEARTBEAT_CYCLES-1. If both are true in the same cycle, exactly one frame is sent.
- cmd is latched into cmd_lat on the trigger cycle. Input changes during a frame do not affect it; they are detected on return to IDLE.
- FSM states:
  - IDLE -> ENC_REQ on trigger; byte index = 0.
  - ENC_REQ: drive enc_data / enc_passthrough for the current byte; assert enc_start for 1 cycle -> ENC_WAIT.
  - ENC_WAIT: enc_data and enc_passthrough held stable. On enc_done, capture enc_result into tx_byte -> LOAD.
  - LOAD: uart_tx = tx_byte; uart_load_data = 1 for 1 cycle -> START.
  - START: start_uart = 1 for 1 cycle -> TX_WAIT. uart_tx holds tx_byte until TX_WAIT exits.
  - TX_WAIT: on tx_done:
    - if byte index < 2: increment index -> ENC_REQ.
    - else: last_cmd <= cmd_lat, frame_count++, pulse frame_sent -> IDLE.
- Byte-to-byte latency: tx_done to the next enc_start is 1 cycle. enc_done to uart_load_data is 1 cycle.
- Input qualification: enc_done is ignored outside ENC_WAIT; tx_done is ignored outside TX_WAIT.
- Timeout:
  - A wait counter clears on entry to ENC_WAIT and TX_WAIT.
  - When it reaches TIMEOUT_CYCLES: pulse timeout_err, go to IDLE, do not update last_cmd (forces a resend), clear hb_cnt.
- Reset asserted mid-frame: immediate return to reset values. No strobes are issued after reset deasserts unless a new trigger occurs.
- busy = (state != IDLE).

Test Plan:
- Release reset with inputs mode=1, upDown=01, forwardBack=10, rightLeft=00; encryption model is XOR 8'h3C when not passthrough.
  -> cmd = 8'hB1.
  -> uart_tx sequence A5, 8D, 28.
  -> one frame_sent pulse; frame_count = 1.
- Inputs held constant, HEARTBEAT_CYCLES = 1000 -> next frame starts exactly 1000 IDLE cycles after return to IDLE, with an identical byte sequence.
- Change rightLeft to 11 while byte1 is in TX_WAIT -> current frame completes with the old cmd; the next frame carries cmd 8'hB7 (encrypted 8'h8B, checksum 8'h2E), started 1 cycle after IDLE entry.
- UART model never returns tx_done, TIMEOUT_CYCLES = 64 -> timeout_err pulses 64 cycles after START; FSM returns to IDLE; the same frame is retried on the next cycle since last_cmd is unchanged.
- Assert reset in ENC_WAIT of byte1 -> all outputs 0 asynchronously; after release, the frame restarts from byte0 (A5).
- Spurious enc_done / tx_done pulses in IDLE and LOAD -> no state change, no strobes.
- Run 256 frames -> frame_count wraps to 0.
